div_detector: RTL

DIV_DETECTOR -- requirements
Module: div_detector

---
 rtl/div_detector.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/div_detector.sv
// -----------------------------------------------------------------------------
// div_detector
// Measures the period and duty cycle of a divided clock (sig_in) that is
// synchronous to clk. Each complete high+low period is checked against the
// duty pattern a divider produces. A good period reports its divisor
// (period - 1). Two consecutive matching good periods raise locked.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low
//   sig_in     : divided clock, already synchronous to clk
//   div_out    : last accepted divisor (period - 1)
//   meas_valid : one-cycle pulse per completed period
//   locked     : two consecutive good measurements agree
//   err        : last completed measurement was bad
//   timeout    : a phase ran 63 cycles without an edge
//
// state | meaning
// ------+-----------------------------------------------------------
// SEEK  | waiting for a rise to start a period; fall/no edge ignored
// HIGH  | counting high cycles in hcnt
// LOW   | counting low cycles in lcnt; next rise closes the period
// -----------------------------------------------------------------------------
module div_detector (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig_in,
  output logic [4:0] div_out,
  output logic       meas_valid,
  output logic       locked,
  output logic       err,
  output logic       timeout
);

  typedef enum logic [1:0] {SEEK, HIGH, LOW} state_t;

  state_t     state_q, state_d;
  logic       sig_d_q;
  logic [5:0] hcnt_q, hcnt_d;
  logic [5:0] lcnt_q, lcnt_d;
  logic [4:0] div_q, div_d;
  logic       mv_q, mv_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic       to_q, to_d;
  logic [4:0] prev_q, prev_d;
  logic       prev_vld_q, prev_vld_d;

  logic       rise, fall;
  logic [6:0] period;
  logic [6:0] period_m1;
  logic       range_ok, duty_ok, good;

  assign rise      = sig_in & ~sig_d_q;
  assign fall      = ~sig_in & sig_d_q;
  assign period    = {1'b0, hcnt_q} + {1'b0, lcnt_q};
  assign period_m1 = period - 7'd1;
  assign range_ok  = (period >= 7'd2) && (period <= 7'd32);
  // Odd divisors put the extra cycle in the low phase.
  assign duty_ok   = period[0] ? ({1'b0, lcnt_q} == ({1'b0, hcnt_q} + 7'd1))
                               : (hcnt_q == lcnt_q);
  assign good      = range_ok && duty_ok;

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    lcnt_d     = lcnt_q;
    div_d      = div_q;
    mv_d       = 1'b0;
    locked_d   = locked_q;
    err_d      = err_q;
    to_d       = to_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;

    case (state_q)
      SEEK: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = 6'd1;
          to_d    = 1'b0;
        end
      end

      HIGH: begin
        if (fall) begin
          state_d = LOW;
          lcnt_d  = 6'd1;
        end else if (hcnt_q >= 6'd62) begin
          state_d    = SEEK;
          to_d       = 1'b1;
          locked_d   = 1'b0;
          prev_vld_d = 1'b0;
          hcnt_d     = 6'd0;
          lcnt_d     = 6'd0;
        end else begin
          hcnt_d = hcnt_q + 6'd1;
        end
      end

      LOW: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = 6'd1;
          lcnt_d  = 6'd0;
          mv_d    = 1'b1;
          if (good) begin
            div_d = period_m1[4:0];
            err_d = 1'b0;
            if (prev_vld_q && (prev_q == period_m1[4:0])) begin
              locked_d = 1'b1;
            end else begin
              locked_d   = 1'b0;
              prev_d     = period_m1[4:0];
              prev_vld_d = 1'b1;
            end
          end else begin
            err_d      = 1'b1;
            locked_d   = 1'b0;
            prev_vld_d = 1'b0;
          end
        end else if (lcnt_q >= 6'd62) begin
          state_d    = SEEK;
          to_d       = 1'b1;
          locked_d   = 1'b0;
          prev_vld_d = 1'b0;
          hcnt_d     = 6'd0;
          lcnt_d     = 6'd0;
        end else begin
          lcnt_d = lcnt_q + 6'd1;
        end
      end

      default: state_d = SEEK;
    endcase
  end

  // sig_d resets high so a signal already high at release is not a rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEEK;
      sig_d_q    <= 1'b1;
      hcnt_q     <= 6'd0;
      lcnt_q     <= 6'd0;
      div_q      <= 5'd0;
      mv_q       <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
      prev_q     <= 5'd0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_d_q    <= sig_in;
      hcnt_q     <= hcnt_d;
      lcnt_q     <= lcnt_d;
      div_q      <= div_d;
      mv_q       <= mv_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      to_q       <= to_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign div_out    = div_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign timeout    = to_q;

endmodule
